// File: rtl/lives_hud_ctrl.sv
// HUD lives strip controller: tracks the life count, blinks the icon just lost,
// and maps the pixel coordinate onto slot offsets for the 32x32 icon drawer.
module lives_hud_ctrl #(
    parameter int TOP_LEFT_X   = 16,
    parameter int TOP_LEFT_Y   = 8,
    parameter int ICON_SIZE    = 32,
    parameter int SLOT_PITCH   = 64,
    parameter int MAX_LIVES    = 5,
    parameter int INIT_LIVES   = 3,
    parameter int BLINK_FRAMES = 48,
    parameter int BLINK_HALF   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        lifeLost,
    input  logic        lifeGained,
    input  logic        gameRestart,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic [3:0]  livesCount,
    output logic        gameOver
);

    localparam int CNT_W  = $clog2(BLINK_FRAMES + 1);
    localparam int HALF_W = $clog2(BLINK_HALF + 1);
    localparam int SHIFT  = $clog2(SLOT_PITCH);

    localparam logic [10:0] TLX        = 11'(TOP_LEFT_X);
    localparam logic [10:0] TLY        = 11'(TOP_LEFT_Y);
    localparam logic [10:0] ICON       = 11'(ICON_SIZE);
    localparam logic [10:0] STRIP_W    = 11'(MAX_LIVES * SLOT_PITCH);
    localparam logic [10:0] PITCH_MASK = 11'(SLOT_PITCH - 1);
    localparam logic [3:0]  MAX_L      = 4'(MAX_LIVES);
    localparam logic [3:0]  INIT_L     = 4'(INIT_LIVES);
    localparam logic [CNT_W-1:0]  FRAMES_END = CNT_W'(BLINK_FRAMES);
    localparam logic [HALF_W-1:0] HALF_END   = HALF_W'(BLINK_HALF);

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        BLINK     = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          lives_q, lives_d;
    logic [3:0]          blink_slot_q, blink_slot_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
    logic                phase_q, phase_d;
    logic                game_over_q, game_over_d;
    logic [10:0]         offset_x_q, offset_x_d;
    logic [10:0]         offset_y_q, offset_y_d;
    logic                inside_q, inside_d;

    logic                single_event;

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        blink_slot_d = blink_slot_q;
        frame_cnt_d  = frame_cnt_q;
        half_cnt_d   = half_cnt_q;
        phase_d      = phase_q;
        single_event = (lifeLost ^ lifeGained) && (state_q != GAME_OVER);

        if (gameRestart) begin
            lives_d     = INIT_L;
            state_d     = ALIVE;
            frame_cnt_d = '0;
            half_cnt_d  = '0;
            phase_d     = 1'b0;
        end else if (single_event) begin
            // Any accepted event restarts the blink timing, even if a frame pulse coincides.
            frame_cnt_d = '0;
            half_cnt_d  = '0;
            if (lifeLost) begin
                if (lives_q > 4'd1) begin
                    lives_d      = lives_q - 4'd1;
                    state_d      = BLINK;
                    blink_slot_d = lives_q - 4'd1;
                    phase_d      = 1'b1;
                end else begin
                    lives_d = 4'd0;
                    state_d = GAME_OVER;
                    phase_d = 1'b0;
                end
            end else if (lives_q < MAX_L) begin
                lives_d = lives_q + 4'd1;
                if (state_q == BLINK && lives_q == blink_slot_q) begin
                    state_d = ALIVE;
                    phase_d = 1'b0;
                end
            end
        end else if (state_q == BLINK && startOfFrame) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            half_cnt_d  = half_cnt_q + 1'b1;
            if (half_cnt_d == HALF_END) begin
                half_cnt_d = '0;
                phase_d    = ~phase_q;
            end
            if (frame_cnt_d == FRAMES_END) begin
                state_d     = ALIVE;
                frame_cnt_d = '0;
                half_cnt_d  = '0;
                phase_d     = 1'b0;
            end
        end

        game_over_d = (state_d == GAME_OVER);
    end

    logic [10:0] rel_x, rel_y, slot, local_x;
    logic        in_band, visible;

    // Geometry looks at the registered count/phase, so the strip follows events one cycle later.
    always_comb begin
        rel_x   = pixelX - TLX;
        rel_y   = pixelY - TLY;
        in_band = (pixelX >= TLX) && (rel_x < STRIP_W) && (pixelY >= TLY) && (rel_y < ICON);
        slot    = rel_x >> SHIFT;
        local_x = rel_x & PITCH_MASK;
        visible = (slot < {7'd0, lives_q}) ||
                  ((state_q == BLINK) && (slot == {7'd0, blink_slot_q}) && phase_q);
        inside_d   = in_band && (local_x < ICON) && visible;
        offset_x_d = inside_d ? local_x : 11'd0;
        offset_y_d = inside_d ? rel_y   : 11'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ALIVE;
            lives_q      <= INIT_L;
            blink_slot_q <= '0;
            frame_cnt_q  <= '0;
            half_cnt_q   <= '0;
            phase_q      <= 1'b0;
            game_over_q  <= 1'b0;
            offset_x_q   <= '0;
            offset_y_q   <= '0;
            inside_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            blink_slot_q <= blink_slot_d;
            frame_cnt_q  <= frame_cnt_d;
            half_cnt_q   <= half_cnt_d;
            phase_q      <= phase_d;
            game_over_q  <= game_over_d;
            offset_x_q   <= offset_x_d;
            offset_y_q   <= offset_y_d;
            inside_q     <= inside_d;
        end
    end

    assign offsetX         = offset_x_q;
    assign offsetY         = offset_y_q;
    assign InsideRectangle = inside_q;
    assign livesCount      = lives_q;
    assign gameOver        = game_over_q;

endmodule

// File: doc/lives_hud_ctrl.md
Name: lives_hud_ctrl

Overview:
Controller for the HUD lives strip. It tracks the player's life count and converts the current VGA pixel coordinate into slot offsets plus an inside-rectangle strobe for the 32x32 life-icon bitmap drawer. After a life is lost, it blinks the lost icon for a fixed number of frames, and it asserts game-over when the count reaches zero. It sits between the game-logic event pulses and the lives bitmap drawer, feeding that drawer's offsetX, offsetY and InsideRectangle inputs.

Parameters:
TOP_LEFT_X, 16, screen X of slot 0's top-left pixel
TOP_LEFT_Y, 8, screen Y of the strip's top row
ICON_SIZE, 32, icon width and height in pixels
SLOT_PITCH, 64, X distance between slot origins; power of two, >= ICON_SIZE
MAX_LIVES, 5, maximum count and number of slots (1..15)
INIT_LIVES, 3, count after reset or restart (1..MAX_LIVES)
BLINK_FRAMES, 48, length of the blink in frames
BLINK_HALF, 8, frames per blink half-period

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
pixelX  in  11  current pixel X
pixelY  in  11  current pixel Y
startOfFrame  in  1  one-cycle pulse per frame
lifeLost  in  1  one-cycle pulse
lifeGained  in  1  one-cycle pulse
gameRestart  in  1  one-cycle pulse
offsetX  out  11  X offset inside the icon (0..ICON_SIZE-1)
offsetY  out  11  Y offset inside the icon
InsideRectangle  out  1  pixel lies on a visible icon
livesCount  out  4  current life count
gameOver  out  1  high while in GAME_OVER

Behaviour:
- One clock (clk). Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: livesCount=INIT_LIVES; state=ALIVE; offsetX=offsetY=0; InsideRectangle=0; gameOver=0; frame counter=0; blink phase=0.
- FSM states are ALIVE, BLINK and GAME_OVER.
- Event priority per cycle, highest first:
  - reset.
  - gameRestart: lives=INIT_LIVES, state=ALIVE, counters cleared.
  - lifeLost and lifeGained together in the same cycle: no change, no blink started.
  - lifeLost or lifeGained alone.
- lifeLost in ALIVE or BLINK:
  - lives>1: lives-=1, state=BLINK, blinkSlot=new lives value (index of the icon just lost), frame counter=0, phase=1 (shown). A lifeLost during BLINK restarts the blink on the new slot.
  - lives==1: lives=0, state=GAME_OVER, gameOver=1 from the next cycle.
- lifeGained in ALIVE or BLINK: lives+=1, saturating at MAX_LIVES; state is unchanged. If the gained slot equals blinkSlot during BLINK, the state goes to ALIVE.
- GAME_OVER ignores lifeLost and lifeGained. Only gameRestart or reset leave it.
- BLINK timing:
  - Each startOfFrame increments the frame counter.
  - Phase toggles every BLINK_HALF frames.
  - When the counter reaches BLINK_FRAMES, state returns to ALIVE.
  - startOfFrame in the same cycle as an event: the event wins and the counter clears.
- Geometry, evaluated combinationally and then registered:
  - relX = pixelX - TOP_LEFT_X; relY = pixelY - TOP_LEFT_Y (11-bit, unsigned wrap).
  - inBand = pixelX >= TOP_LEFT_X and relX < MAX_LIVES*SLOT_PITCH and pixelY >= TOP_LEFT_Y and relY < ICON_SIZE.
  - slot = relX >> log2(SLOT_PITCH); local = relX & (SLOT_PITCH-1).
  - visible = slot < livesCount, or (state==BLINK and slot==blinkSlot and phase==1).
  - InsideRectangle = inBand and local < ICON_SIZE and visible.
  - When InsideRectangle=1: offsetX=local, offsetY=relY. Otherwise both are 0.
- Latency: one clk from pixelX/pixelY to offsetX, offsetY and InsideRectangle. The combined path into the bitmap drawer is therefore two cycles.
- livesCount and gameOver are registered and update one cycle after the event.
- Geometry uses the livesCount and phase registered before the current cycle. No mid-line glitch protection is required.

Test Plan:
- Reset, then scan pixelY=8, pixelX=16..335 -> InsideRectangle high for X 16..47, 80..111, 144..175, one cycle late; offsetX 0..31 in each run; livesCount=3, gameOver=0.
- At pixel (100,20) -> next cycle offsetX=20, offsetY=12, InsideRectangle=1. At (60,20) (gap) -> InsideRectangle=0, offsets 0.
- lifeLost with 3 lives -> livesCount=2, state BLINK, slot 2 (X 144..175) drawn during frames 0-7, hidden frames 8-15, and so on. After 48 startOfFrame pulses -> slot 2 hidden permanently, state ALIVE.
- lifeGained pulsed 4 times from 3 lives -> livesCount saturates at 5; slot 4 (X 272..303) visible.
- lifeLost and lifeGained in the same cycle with 3 lives -> livesCount stays 3, no blink.
- Three lifeLost pulses from 3 lives -> livesCount=0 and gameOver=1; strip fully blank; further lifeLost/lifeGained ignored. gameRestart -> livesCount=3, gameOver=0. Reset asserted mid-BLINK -> all outputs at reset values on the next edge.
